// File: rtl/memoria_pkg.sv
// Shared types, default parameters and width helpers for the synchronous data memory.
package memoria_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int    DEF_DATA_W         = 32;
  localparam int    DEF_DEPTH          = 128;
  localparam int    DEF_ADDR_W         = 32;
  localparam int    DEF_CLEAR_ON_RESET = 1;
  localparam string DEF_INIT_FILE      = "datosmemoria";

  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int off_w_of(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int idx_w_of(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_addr_check.sv
// Combinational address decode: word index plus alignment, range and conflict checks.
module mem_addr_check
  import memoria_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int IDX_W = idx_w_of(DEPTH)
) (
  input  logic [ADDR_W-1:0] Address,
  input  logic              W,
  input  logic              R,
  output logic [IDX_W-1:0]  idx,
  output logic              misaligned,
  output logic              out_of_range,
  output logic              reject
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int OFF_W = off_w_of(DATA_W);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
  // One extra bit so DEPTH*BYTES is representable even when it fills the address space.
  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(DEPTH * BYTES);

  assign idx          = Address[OFF_W +: IDX_W];
  assign misaligned   = (Address & OFF_MASK) != '0;
  assign out_of_range = {1'b0, Address} >= LIMIT;
  assign reject       = (W | R) & (misaligned | out_of_range | (W & R));

endmodule

// File: rtl/memoria_datos_sync.sv
// Clocked data memory: registered reads, byte-lane writes, request checking and power-up clear.
module memoria_datos_sync
  import memoria_pkg::*;
#(
  parameter int    DATA_W         = DEF_DATA_W,
  parameter int    DEPTH          = DEF_DEPTH,
  parameter int    ADDR_W         = DEF_ADDR_W,
  parameter int    CLEAR_ON_RESET = DEF_CLEAR_ON_RESET,
  parameter string INIT_FILE      = DEF_INIT_FILE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   Address,
  input  logic [DATA_W-1:0]   DataIn,
  input  logic [DATA_W/8-1:0] ByteEn,
  input  logic                W,
  input  logic                R,
  output logic                Ready,
  output logic [DATA_W-1:0]   DataOut,
  output logic                DataValid,
  output logic                Err
);

  localparam int BYTES = bytes_of(DATA_W);
  localparam int IDX_W = idx_w_of(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state, state_next;
  logic [IDX_W-1:0]  cnt;
  logic [IDX_W-1:0]  idx;
  logic              misaligned, out_of_range, reject;
  logic              addr_flags_unused;
  logic              accept_w, accept_r;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic [BYTES-1:0]  wr_be;

  mem_addr_check #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_addr_check (
    .Address      (Address),
    .W            (W),
    .R            (R),
    .idx          (idx),
    .misaligned   (misaligned),
    .out_of_range (out_of_range),
    .reject       (reject)
  );

  // Individual fault causes are only of interest when probing the design.
  assign addr_flags_unused = misaligned | out_of_range;

  assign Ready    = (state == RUN);
  assign accept_w = Ready & W & ~reject;
  assign accept_r = Ready & R & ~reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cnt <= cnt + 1'b1;
    end
  end

  // The clear sequence and normal writes share the single RAM write port.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_idx     = idx;
    wr_data    = DataIn;
    wr_be      = ByteEn;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_idx  = cnt;
        wr_data = '0;
        wr_be   = '1;
        if (cnt == IDX_W'(DEPTH - 1)) state_next = RUN;
      end
      RUN: wr_en = accept_w;
    endcase
    if (rst) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BYTES; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      DataOut <= '0;
    end else if (accept_r) begin
      DataOut <= mem[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      DataValid <= 1'b0;
      Err       <= 1'b0;
    end else begin
      DataValid <= accept_r;
      Err       <= Ready & reject;
    end
  end

endmodule

// File: tb/tb_memoria_datos_sync.sv
// Directed bench for memoria_datos_sync: vector table plus reset/clear sequences.
module tb_memoria_datos_sync;

  logic        clk;
  logic        rst;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [3:0]  ByteEn;
  logic        W;
  logic        R;
  logic        Ready;
  logic [31:0] DataOut;
  logic        DataValid;
  logic        Err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  be;
    logic        w;
    logic        r;
    logic [31:0] dout;
    logic        valid;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  memoria_datos_sync #(
    .DATA_W         (32),
    .DEPTH          (128),
    .ADDR_W         (32),
    .CLEAR_ON_RESET (1),
    .INIT_FILE      ("")
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .Address   (Address),
    .DataIn    (DataIn),
    .ByteEn    (ByteEn),
    .W         (W),
    .R         (R),
    .Ready     (Ready),
    .DataOut   (DataOut),
    .DataValid (DataValid),
    .Err       (Err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] addr, input logic [31:0] din, input logic [3:0] be,
                         input logic w, input logic r, input logic [31:0] dout,
                         input logic valid, input logic err);
    vecs.push_back('{addr: addr, din: din, be: be, w: w, r: r,
                     dout: dout, valid: valid, err: err});
  endtask

  // Counts cycles until Ready rises; optionally issues a write to 0x40 late in the clear.
  task automatic wait_ready(input bit poke, output int n, output bit err_seen);
    n = 0;
    err_seen = 1'b0;
    while (!Ready && n < 300) begin
      if (poke && n >= 115) begin
        W = 1'b1; Address = 32'h40; DataIn = 32'hBADBAD00; ByteEn = 4'hF;
      end
      tick();
      n++;
      if (Err) err_seen = 1'b1;
    end
    W = 1'b0;
  endtask

  initial begin
    int  n;
    bit  err_seen;

    rst = 1'b0; W = 1'b0; R = 1'b0;
    Address = '0; DataIn = '0; ByteEn = '0;
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_ready",   Ready,     0);
    check("reset_dataout", DataOut,   0);
    check("reset_valid",   DataValid, 0);
    check("reset_err",     Err,       0);

    wait_ready(1'b1, n, err_seen);
    check("clear_cycles",    n,        128);
    check("clear_no_err",    err_seen, 0);
    check("ready_after_clr", Ready,    1);

    add_vec(32'h1FC, 32'h0,        4'h0, 0, 1, 32'h00000000, 1, 0);
    add_vec(32'h040, 32'h0,        4'h0, 0, 1, 32'h00000000, 1, 0);
    add_vec(32'h010, 32'hDEADBEEF, 4'hF, 1, 0, 32'h00000000, 0, 0);
    add_vec(32'h010, 32'h0,        4'h0, 0, 1, 32'hDEADBEEF, 1, 0);
    add_vec(32'h010, 32'h000000AA, 4'h1, 1, 0, 32'hDEADBEEF, 0, 0);
    add_vec(32'h010, 32'h0,        4'h0, 0, 1, 32'hDEADBEAA, 1, 0);
    add_vec(32'h014, 32'h11223344, 4'hA, 1, 0, 32'hDEADBEAA, 0, 0);
    add_vec(32'h014, 32'h0,        4'h0, 0, 1, 32'h11003300, 1, 0);
    add_vec(32'h014, 32'hFFFFFFFF, 4'h0, 1, 0, 32'h11003300, 0, 0);
    add_vec(32'h014, 32'h0,        4'h0, 0, 1, 32'h11003300, 1, 0);
    add_vec(32'h013, 32'h0,        4'h0, 0, 1, 32'h11003300, 0, 1);
    add_vec(32'h200, 32'h0,        4'h0, 0, 1, 32'h11003300, 0, 1);
    add_vec(32'h020, 32'h55555555, 4'hF, 1, 1, 32'h11003300, 0, 1);
    add_vec(32'h000, 32'h0,        4'h0, 0, 0, 32'h11003300, 0, 0);
    add_vec(32'h020, 32'h0,        4'h0, 0, 1, 32'h00000000, 1, 0);
    add_vec(32'h1FC, 32'hCAFEF00D, 4'hC, 1, 0, 32'h00000000, 0, 0);
    add_vec(32'h1FD, 32'hFFFFFFFF, 4'hF, 1, 0, 32'h00000000, 0, 1);
    add_vec(32'h1FC, 32'h0,        4'h0, 0, 1, 32'hCAFE0000, 1, 0);
    add_vec(32'h200, 32'h77777777, 4'hF, 1, 0, 32'hCAFE0000, 0, 1);
    add_vec(32'h000, 32'h0,        4'h0, 0, 1, 32'h00000000, 1, 0);
    add_vec(32'h040, 32'h12345678, 4'hF, 1, 0, 32'h00000000, 0, 0);
    add_vec(32'h040, 32'h0,        4'h0, 0, 1, 32'h12345678, 1, 0);
    add_vec(32'h040, 32'hA5A5A5A5, 4'h3, 1, 0, 32'h12345678, 0, 0);
    add_vec(32'h040, 32'h0,        4'h0, 0, 1, 32'h1234A5A5, 1, 0);

    foreach (vecs[i]) begin
      Address = vecs[i].addr;
      DataIn  = vecs[i].din;
      ByteEn  = vecs[i].be;
      W       = vecs[i].w;
      R       = vecs[i].r;
      tick();
      check($sformatf("vec%0d_dataout", i), DataOut,   vecs[i].dout);
      check($sformatf("vec%0d_valid", i),   DataValid, 32'(vecs[i].valid));
      check($sformatf("vec%0d_err", i),     Err,       32'(vecs[i].err));
    end
    W = 1'b0; R = 1'b0;

    // Reset from RUN, then a second reset 60 cycles into the clear.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rerun_ready",   Ready,   0);
    check("rerun_dataout", DataOut, 0);
    repeat (60) tick();
    check("midclear_ready", Ready, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(1'b0, n, err_seen);
    check("midclear_cycles", n,        128);
    check("midclear_no_err", err_seen, 0);

    Address = 32'h40; R = 1'b1;
    tick();
    R = 1'b0;
    check("recleared_dataout", DataOut,   0);
    check("recleared_valid",   DataValid, 1);
    tick();
    check("valid_pulse_end", DataValid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
